// File: rtl/keypad_scan_queue.sv
// Keypad matrix front end: one-hot column scan, per-frame lowest-code candidate,
// debounce/auto-repeat FSM and a key-code FIFO with valid/ready and sticky overflow.
module keypad_scan_queue #(
    parameter int unsigned ROWS          = 4,
    parameter int unsigned COLS          = 4,
    parameter int unsigned SCAN_DIV      = 8,
    parameter int unsigned DEBOUNCE      = 3,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned REPEAT_FRAMES = 0
) (
    input  logic                          clk,
    input  logic                          nRST,
    input  logic [ROWS-1:0]               RowIn,
    output logic [COLS-1:0]               ColOut,
    output logic [$clog2(ROWS*COLS)-1:0]  key_code,
    output logic                          key_valid,
    input  logic                          key_ready,
    output logic                          key_held,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clr_overflow
);
    localparam int unsigned CODE_W = $clog2(ROWS * COLS);
    localparam int unsigned COL_W  = $clog2(COLS);
    localparam int unsigned DW_W   = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE + 1);
    localparam int unsigned REP_W  = (REPEAT_FRAMES < 1) ? 1 : $clog2(REPEAT_FRAMES + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_PRESS_WAIT, S_HELD, S_REL_WAIT} state_t;

    logic [ROWS-1:0]   row_s1_q, row_s2_q;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [COL_W-1:0]  col_idx_q, col_idx_d;
    logic [COLS-1:0]   col_q, col_d;
    logic              acc_found_q, acc_found_d;
    logic [CODE_W-1:0] acc_code_q, acc_code_d;
    logic              sample_c, frame_end_c, samp_found_c, cand_found_c;
    logic [CODE_W-1:0] samp_code_c, cand_code_c;

    state_t            state_q, state_d;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              key_held_q, key_held_d;
    logic              push_c;
    logic [CODE_W-1:0] push_code_c;

    logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
    logic [CODE_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] count_q, count_d;
    logic              overflow_q, overflow_d, key_valid_q, key_valid_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              pop_c, full_c, wr_en_c;

    // Column dwell counter and one-hot column rotation.
    always_comb begin
        sample_c    = (dwell_q == DW_W'(SCAN_DIV - 1));
        frame_end_c = sample_c && (col_idx_q == COL_W'(COLS - 1));
        dwell_d     = sample_c ? '0 : dwell_q + DW_W'(1);
        col_idx_d   = col_idx_q;
        col_d       = col_q;
        if (sample_c) begin
            col_idx_d = frame_end_c ? '0 : col_idx_q + COL_W'(1);
            col_d     = {col_q[COLS-2:0], col_q[COLS-1]};
        end
    end

    // Lowest code seen so far this frame, merged with the current column sample.
    always_comb begin
        samp_found_c = 1'b0;
        samp_code_c  = '0;
        for (int r = int'(ROWS) - 1; r >= 0; r--) begin
            if (row_s2_q[r]) begin
                samp_found_c = 1'b1;
                samp_code_c  = CODE_W'(r * int'(COLS) + int'(col_idx_q));
            end
        end
        cand_found_c = acc_found_q | samp_found_c;
        cand_code_c  = (acc_found_q && (!samp_found_c || acc_code_q < samp_code_c))
                       ? acc_code_q : samp_code_c;
        acc_found_d  = acc_found_q;
        acc_code_d   = acc_code_q;
        if (frame_end_c) begin
            acc_found_d = 1'b0;
            acc_code_d  = '0;
        end else if (sample_c) begin
            acc_found_d = cand_found_c;
            acc_code_d  = cand_code_c;
        end
    end

    // Debounce / auto-repeat FSM, evaluated once per frame.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        rep_d       = rep_q;
        push_c      = 1'b0;
        push_code_c = cand_q;
        if (frame_end_c) begin
            case (state_q)
                S_IDLE: begin
                    if (cand_found_c) begin
                        cand_d = cand_code_c;
                        cnt_d  = CNT_W'(1);
                        rep_d  = '0;
                        if (DEBOUNCE == 1) begin
                            state_d     = S_HELD;
                            push_c      = 1'b1;
                            push_code_c = cand_code_c;
                        end else begin
                            state_d = S_PRESS_WAIT;
                        end
                    end
                end
                S_PRESS_WAIT: begin
                    if (!cand_found_c) begin
                        state_d = S_IDLE;
                    end else if (cand_code_c != cand_q) begin
                        cand_d = cand_code_c;
                        cnt_d  = CNT_W'(1);
                    end else if (32'(cnt_q) + 32'd1 >= DEBOUNCE) begin
                        state_d = S_HELD;
                        push_c  = 1'b1;
                        rep_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_HELD: begin
                    if (cand_found_c && cand_code_c == cand_q) begin
                        if (REPEAT_FRAMES != 0) begin
                            if (32'(rep_q) + 32'd1 == REPEAT_FRAMES) begin
                                push_c = 1'b1;
                                rep_d  = '0;
                            end else begin
                                rep_d = rep_q + REP_W'(1);
                            end
                        end
                    end else if (DEBOUNCE == 1 && !cand_found_c) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_REL_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
                S_REL_WAIT: begin
                    if (!cand_found_c) begin
                        if (32'(cnt_q) + 32'd1 >= DEBOUNCE) state_d = S_IDLE;
                        else cnt_d = cnt_q + CNT_W'(1);
                    end else if (cand_code_c == cand_q) begin
                        state_d = S_HELD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        key_held_d = (state_d == S_HELD) || (state_d == S_REL_WAIT);
    end

    // FIFO: a push into a full queue is only dropped when no pop frees a slot.
    always_comb begin
        pop_c    = key_valid_q & key_ready;
        full_c   = (count_q == FCNT_W'(FIFO_DEPTH));
        wr_en_c  = push_c & (!full_c | pop_c);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_c) begin
            mem_d[wr_ptr_q] = push_code_c;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (wr_en_c && !pop_c)      count_d = count_q + FCNT_W'(1);
        else if (!wr_en_c && pop_c) count_d = count_q - FCNT_W'(1);
        overflow_d = overflow_q;
        if (push_c && full_c && !pop_c) overflow_d = 1'b1;
        else if (clr_overflow)          overflow_d = 1'b0;
        key_valid_d = (count_d != '0);
        key_code_d  = key_valid_d ? mem_d[rd_ptr_d] : key_code_q;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            row_s1_q    <= '0;
            row_s2_q    <= '0;
            dwell_q     <= '0;
            col_idx_q   <= '0;
            col_q       <= COLS'(1);
            acc_found_q <= 1'b0;
            acc_code_q  <= '0;
            state_q     <= S_IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            rep_q       <= '0;
            key_held_q  <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            row_s1_q    <= RowIn;
            row_s2_q    <= row_s1_q;
            dwell_q     <= dwell_d;
            col_idx_q   <= col_idx_d;
            col_q       <= col_d;
            acc_found_q <= acc_found_d;
            acc_code_q  <= acc_code_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            rep_q       <= rep_d;
            key_held_q  <= key_held_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    assign ColOut     = col_q;
    assign key_code   = key_code_q;
    assign key_valid  = key_valid_q;
    assign key_held   = key_held_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_keypad_scan_queue.sv
// Directed bench: a keypad matrix model drives RowIn from ColOut; one instance without
// and one with auto-repeat (REPEAT_FRAMES=2), both at SCAN_DIV=4, DEBOUNCE=2.
module tb_keypad_scan_queue;
    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic [15:0] keys = '0, keys2 = '0;
    logic [3:0]  row_in, row_in2, col_out, col_out2;
    logic [3:0]  key_code, key_code2;
    logic        key_valid, key_valid2, key_ready = 1'b0, ready2 = 1'b0;
    logic        key_held, key_held2, overflow, overflow2;
    logic        clr_overflow = 1'b0, clr2 = 1'b0;
    logic [2:0]  fifo_count, fifo_count2;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    keypad_scan_queue #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(2), .FIFO_DEPTH(4),
                        .REPEAT_FRAMES(0)) dut (
        .clk(clk), .nRST(nRST), .RowIn(row_in), .ColOut(col_out), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held),
        .fifo_count(fifo_count), .overflow(overflow), .clr_overflow(clr_overflow));

    keypad_scan_queue #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(2), .FIFO_DEPTH(4),
                        .REPEAT_FRAMES(2)) dut_rep (
        .clk(clk), .nRST(nRST), .RowIn(row_in2), .ColOut(col_out2), .key_code(key_code2),
        .key_valid(key_valid2), .key_ready(ready2), .key_held(key_held2),
        .fifo_count(fifo_count2), .overflow(overflow2), .clr_overflow(clr2));

    // Key at code r*4+c connects column c to row r.
    always_comb begin
        row_in  = '0;
        row_in2 = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (col_out[c]  && keys[r*4+c])  row_in[r]  = 1'b1;
                if (col_out2[c] && keys2[r*4+c]) row_in2[r] = 1'b1;
            end
        end
    end

    task automatic do_reset();
        nRST = 1'b0; keys = '0; keys2 = '0; key_ready = 1'b0; ready2 = 1'b0;
        clr_overflow = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nRST = 1'b1;
    endtask

    // Waits for the first frame-end edge (ColOut wraps 1000 -> 0001), bounded.
    task automatic sync_frame();
        logic [3:0] prev;
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            prev = col_out;
            @(posedge clk); #1;
            if (prev == 4'b1000 && col_out == 4'b0001) ok = 1;
        end
        total++;
        if (!ok) begin bad++; $display("FAIL sync_frame: ColOut=%b want wrap to 0001", col_out); end
    endtask

    // From #1 after a frame-end edge, advance to #1 after the next one; rdy/clr apply on that edge.
    task automatic frame_edge(input logic rdy, input logic clr, input int skip);
        repeat (15 - skip) @(posedge clk);
        #1; key_ready = rdy; clr_overflow = clr;
        @(posedge clk); #1;
        key_ready = 1'b0; clr_overflow = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (col_out !== 4'b0001) begin bad++; $display("FAIL rst_col: got %b want 0001", col_out); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", key_valid); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL rst_held: got %b want 0", key_held); end
        total++; if (key_code !== 4'd0) begin bad++; $display("FAIL rst_code: got %0d want 0", key_code); end
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp_col;
        do_reset();
        for (int k = 0; k < 64; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            exp_col = 4'b0001 << ((k / 4) % 4);
            total++;
            if (col_out !== exp_col) begin bad++; $display("FAIL scan_col k=%0d: got %b want %b", k, col_out, exp_col); end
        end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL idle_valid: got %b want 0", key_valid); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL idle_count: got %0d want 0", fifo_count); end
    endtask

    task automatic test_press_release();
        do_reset(); sync_frame();
        keys[9] = 1'b1;
        frame_edge(1'b0, 1'b0, 0);
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL press_f1_count: got %0d want 0", fifo_count); end
        frame_edge(1'b0, 1'b0, 0);
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL press_valid: got %b want 1", key_valid); end
        total++; if (key_code !== 4'd9) begin bad++; $display("FAIL press_code: got %0d want 9", key_code); end
        total++; if (key_held !== 1'b1) begin bad++; $display("FAIL press_held: got %b want 1", key_held); end
        frame_edge(1'b0, 1'b0, 0);
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL press_f3_count: got %0d want 1", fifo_count); end
        keys = '0;
        frame_edge(1'b0, 1'b0, 0);
        total++; if (key_held !== 1'b1) begin bad++; $display("FAIL relwait_held: got %b want 1", key_held); end
        frame_edge(1'b0, 1'b0, 0);
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL release_held: got %b want 0", key_held); end
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL release_count: got %0d want 1", fifo_count); end
    endtask

    task automatic test_glitch_bounce();
        do_reset(); sync_frame();
        keys[5] = 1'b1; frame_edge(1'b0, 1'b0, 0);
        keys = '0;      frame_edge(1'b0, 1'b0, 0);
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL glitch_held: got %b want 0", key_held); end
        frame_edge(1'b0, 1'b0, 0);
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL glitch_count: got %0d want 0", fifo_count); end
        keys[5] = 1'b1; frame_edge(1'b0, 1'b0, 0);
        keys = '0;      frame_edge(1'b0, 1'b0, 0);
        keys[5] = 1'b1; frame_edge(1'b0, 1'b0, 0);
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL bounce_early: got %0d want 0", fifo_count); end
        frame_edge(1'b0, 1'b0, 0);
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL bounce_count: got %0d want 1", fifo_count); end
        total++; if (key_code !== 4'd5) begin bad++; $display("FAIL bounce_code: got %0d want 5", key_code); end
    endtask

    task automatic test_multi_key();
        do_reset(); sync_frame();
        keys[3] = 1'b1; keys[12] = 1'b1;
        frame_edge(1'b0, 1'b0, 0);
        frame_edge(1'b0, 1'b0, 0);
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL multi_count: got %0d want 1", fifo_count); end
        total++; if (key_code !== 4'd3) begin bad++; $display("FAIL multi_code: got %0d want 3", key_code); end
    endtask

    task automatic test_overflow();
        int codes [5];
        codes = '{1, 2, 4, 6, 8};
        do_reset(); sync_frame();
        for (int i = 0; i < 5; i++) begin
            keys = 16'(1) << codes[i];
            frame_edge(1'b0, 1'b0, 0); frame_edge(1'b0, 1'b0, 0);
            keys = '0;
            frame_edge(1'b0, 1'b0, 0); frame_edge(1'b0, 1'b0, 0);
            if (i == 3) begin
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_at4: got %b want 0", overflow); end
            end
        end
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        total++; if (key_code !== 4'd1) begin bad++; $display("FAIL ovf_head: got %0d want 1", key_code); end
        frame_edge(1'b0, 1'b1, 0);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %b want 0", overflow); end
        // Pop and push on the same edge while full.
        keys[10] = 1'b1;
        frame_edge(1'b0, 1'b0, 0);
        frame_edge(1'b1, 1'b0, 0);
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL pp_count: got %0d want 4", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pp_ovf: got %b want 0", overflow); end
        total++; if (key_code !== 4'd2) begin bad++; $display("FAIL pp_head: got %0d want 2", key_code); end
        keys = '0;
        frame_edge(1'b0, 1'b0, 0); frame_edge(1'b0, 1'b0, 0);
        // Dropped push with clr_overflow on the same edge: set wins.
        keys[11] = 1'b1;
        frame_edge(1'b0, 1'b0, 0);
        frame_edge(1'b0, 1'b1, 0);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL setwins_ovf: got %b want 1", overflow); end
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL setwins_count: got %0d want 4", fifo_count); end
    endtask

    task automatic test_repeat();
        int exp_cnt [7];
        int skip;
        exp_cnt = '{0, 1, 1, 2, 2, 3, 3};
        do_reset(); sync_frame();
        keys2[7] = 1'b1;
        for (int f = 0; f < 7; f++) begin
            frame_edge(1'b0, 1'b0, 0);
            total++;
            if (fifo_count2 !== 3'(exp_cnt[f])) begin
                bad++; $display("FAIL rep_count f%0d: got %0d want %0d", f + 1, fifo_count2, exp_cnt[f]);
            end
        end
        total++; if (key_code2 !== 4'd7) begin bad++; $display("FAIL rep_code: got %0d want 7", key_code2); end
        // With the consumer always ready each pushed code leaves one cycle later.
        do_reset(); sync_frame();
        ready2 = 1'b1; keys2[7] = 1'b1;
        skip = 0;
        for (int f = 1; f <= 6; f++) begin
            frame_edge(1'b0, 1'b0, skip);
            skip = 0;
            if (f % 2 == 0) begin
                total++; if (key_valid2 !== 1'b1) begin bad++; $display("FAIL rdy_valid f%0d: got %b want 1", f, key_valid2); end
                total++; if (key_code2 !== 4'd7) begin bad++; $display("FAIL rdy_code f%0d: got %0d want 7", f, key_code2); end
                @(posedge clk); #1;
                total++; if (key_valid2 !== 1'b0) begin bad++; $display("FAIL rdy_pop f%0d: got %b want 0", f, key_valid2); end
                skip = 1;
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(); sync_frame();
        for (int i = 0; i < 2; i++) begin
            keys = 16'(1) << (i + 1);
            frame_edge(1'b0, 1'b0, 0); frame_edge(1'b0, 1'b0, 0);
            keys = '0;
            frame_edge(1'b0, 1'b0, 0); frame_edge(1'b0, 1'b0, 0);
        end
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL mid_pre_count: got %0d want 2", fifo_count); end
        keys[4] = 1'b1;
        frame_edge(1'b0, 1'b0, 0);
        repeat (5) @(posedge clk);
        #1; nRST = 1'b0; #1;
        total++; if (col_out !== 4'b0001) begin bad++; $display("FAIL mid_col: got %b want 0001", col_out); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", fifo_count); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", key_valid); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_ovf: got %b want 0", overflow); end
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        sync_frame();
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL mid_lost: got %0d want 0", fifo_count); end
        frame_edge(1'b0, 1'b0, 0);
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL mid_repress: got %0d want 1", fifo_count); end
        total++; if (key_code !== 4'd4) begin bad++; $display("FAIL mid_code: got %0d want 4", key_code); end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_press_release();
        test_glitch_bounce();
        test_multi_key();
        test_overflow();
        test_repeat();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
